// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 host transmitter.
//   ps2_state_e      : transmit FSM states
//   ACK_OK / ACK_ERR : encodings of the latched device acknowledge
//   FILT_LEN         : cycles the synchronized clock must be stable on each side of a falling edge
//   POS_STOP         : shift position of the stop bit (0..7 data, 8 parity, 9 stop)
//   us_to_cycles / ms_to_cycles / cnt_width : cycle-count helpers for the timers
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic       ACK_OK   = 1'b1;
    localparam logic       ACK_ERR  = 1'b0;
    localparam int         FILT_LEN = 4;
    localparam logic [3:0] POS_STOP = 4'd9;

    // 64-bit intermediate: 120 us * 100 MHz overflows 32 bits.
    function automatic int us_to_cycles(input int hz, input int us);
        return int'((longint'(hz) * longint'(us)) / longint'(1_000_000));
    endfunction

    function automatic int ms_to_cycles(input int hz, input int ms);
        return int'((longint'(hz) * longint'(ms)) / longint'(1_000));
    endfunction

    // Width of a counter that must hold 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter -- 2-flop synchronizers for the raw PS/2 lines plus a
// glitch-filtered falling-edge detector on the clock line.
//   clk, rst_n   : system clock, async active-low reset
//   i_clk_raw    : raw PS/2 clock line
//   i_data_raw   : raw PS/2 data line
//   o_clk_s      : synchronized clock line
//   o_data_s     : synchronized data line
//   o_fall       : one-cycle pulse on a filtered falling edge
module ps2_edge_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clk_raw,
    input  logic i_data_raw,
    output logic o_clk_s,
    output logic o_data_s,
    output logic o_fall
);

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_data_sync;
    logic [FILT_LEN-1:0] r_hist;
    logic                r_filt;

    // Idle bus is high, so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_hist      <= '1;
            r_filt      <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_clk_raw};
            r_data_sync <= {r_data_sync[0], i_data_raw};
            r_hist      <= {r_hist[FILT_LEN-2:0], r_clk_sync[1]};
            // Filtered level only flips after FILT_LEN identical samples.
            if (&r_hist)
                r_filt <= 1'b1;
            else if (~|r_hist)
                r_filt <= 1'b0;
        end
    end

    assign o_clk_s  = r_clk_sync[1];
    assign o_data_s = r_data_sync[1];
    // Filtered level was high and the last FILT_LEN samples are all low.
    assign o_fall   = r_filt & ~|r_hist;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter (open-drain outputs).
//   Parameters: CLK_HZ (system clock), INHIBIT_US (clock-low inhibit),
//               TIMEOUT_MS (device-clocking watchdog limit)
//   tx_valid/tx_data/tx_ready : byte request handshake, accepted in IDLE only
//   tx_done / tx_err          : one-cycle completion pulses (ACK seen / not seen or timeout)
//   busy                      : high from acceptance to completion
//   PS2_clk/PS2_data          : raw bus lines
//   PS2_clk_oe/PS2_data_oe    : 1 pulls the corresponding line low
// Optional feature: define PS2_TX_WATCHDOG_EN to add the device-clocking watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic       PS2_clk_oe,
    output logic       PS2_data_oe
);

    localparam int INH_RAW = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int INH_CYC = (INH_RAW < 1) ? 1 : INH_RAW;
    localparam int INH_W   = cnt_width(INH_CYC);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);

    ps2_state_e       r_state, w_next;
    logic [7:0]       r_byte;
    logic             r_par;
    logic [3:0]       r_pos;
    logic [INH_W-1:0] r_inh_cnt;
    logic             r_ack_ok;
    logic             w_clk_s, w_data_s, w_fall;
    logic             w_inh_last;
    logic             w_lines_high;
    logic [9:0]       w_frame;
    logic             w_wd_exp;

    ps2_edge_filter u_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clk_raw  (PS2_clk),
        .i_data_raw (PS2_data),
        .o_clk_s    (w_clk_s),
        .o_data_s   (w_data_s),
        .o_fall     (w_fall)
    );

    assign w_inh_last   = (r_state == ST_INHIBIT) && (r_inh_cnt == INH_LAST);
    assign w_lines_high = w_clk_s & w_data_s;
    // Bits in shift order: data[0..7], parity, stop.
    assign w_frame      = {1'b1, r_par, r_byte};

`ifdef PS2_TX_WATCHDOG_EN
    localparam int WD_RAW = ms_to_cycles(CLK_HZ, TIMEOUT_MS);
    localparam int WD_CYC = (WD_RAW < 1) ? 1 : WD_RAW;
    localparam int WD_W   = cnt_width(WD_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYC - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_wd_run;

    assign w_wd_run = (r_state == ST_REQ) || (r_state == ST_SHIFT) ||
                      (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
    assign w_wd_exp = w_wd_run && (r_wd_cnt == WD_LAST);

    // Restarts on every device edge, so it only fires if the device stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wd_cnt <= '0;
        else if (!w_wd_run || w_fall)
            r_wd_cnt <= '0;
        else
            r_wd_cnt <= r_wd_cnt + 1'b1;
    end
`else
    assign w_wd_exp = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic. Falls in IDLE/INHIBIT are deliberately ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (tx_valid)                        w_next = ST_INHIBIT;
            ST_INHIBIT:   if (w_inh_last)                      w_next = ST_REQ;
            ST_REQ:       if (w_fall)                          w_next = ST_SHIFT;
            ST_SHIFT:     if (w_fall && (r_pos == POS_STOP))   w_next = ST_ACK;
            ST_ACK:                                            w_next = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (w_lines_high)                    w_next = ST_IDLE;
            default:                                           w_next = ST_IDLE;
        endcase
        if (w_wd_exp)
            w_next = ST_IDLE;
    end

    // Datapath: latched byte, inhibit timer, shift position, ACK capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_pos     <= '0;
            r_inh_cnt <= '0;
            r_ack_ok  <= ACK_ERR;
        end else begin
            case (r_state)
                ST_IDLE: if (tx_valid) begin
                    r_byte    <= tx_data;
                    r_par     <= ~^tx_data;
                    r_pos     <= '0;
                    r_inh_cnt <= '0;
                    r_ack_ok  <= ACK_ERR;
                end
                ST_INHIBIT: if (!w_inh_last)
                    r_inh_cnt <= r_inh_cnt + 1'b1;
                // The REQ->SHIFT edge presents position 0; later edges advance.
                ST_SHIFT: if (w_fall) begin
                    if (r_pos != POS_STOP)
                        r_pos <= r_pos + 4'd1;
                    else
                        r_ack_ok <= w_data_s ? ACK_ERR : ACK_OK;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from registered state so an async reset releases
    // the bus in the same instant.
    always_comb begin
        tx_ready    = (r_state == ST_IDLE);
        busy        = (r_state != ST_IDLE);
        PS2_clk_oe  = (r_state == ST_INHIBIT);
        PS2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_err      = w_wd_exp;
        case (r_state)
            ST_INHIBIT:   PS2_data_oe = w_inh_last;
            ST_REQ:       PS2_data_oe = 1'b1;
            ST_SHIFT:     PS2_data_oe = ~w_frame[r_pos];
            ST_WAIT_IDLE: if (w_lines_high && !w_wd_exp) begin
                tx_done = (r_ack_ok == ACK_OK);
                tx_err  = (r_ack_ok == ACK_ERR);
            end
            default: ;
        endcase
        if (w_wd_exp) begin
            PS2_clk_oe  = 1'b0;
            PS2_data_oe = 1'b0;
        end
    end

endmodule
